// File: rtl/rfifo_burst_drain_ctrl_if.sv
// Burst output stream of the async-FIFO read-side drain controller.
// Master drives data/valid/last; slave returns ready.
interface rfifo_burst_drain_ctrl_if #(
  parameter int DATASIZE = 8
);
  logic [DATASIZE-1:0] m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/rfifo_burst_drain_ctrl.sv
// Read-domain async-FIFO controller: owns rptr, drains words as bursts.
// Optional partial-burst timeout: define RFIFO_DRAIN_TIMEOUT_EN.
module rfifo_burst_drain_ctrl #(
  parameter int ADDRSIZE       = 4,
  parameter int DATASIZE       = 8,
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                flush,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                busy,
  rfifo_burst_drain_ctrl_if.master m
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] BL = PW'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_rbin;
  logic [PW-1:0]       r_rptr;
  logic                r_rempty;
  logic [PW-1:0]       r_blen;
  logic [PW-1:0]       r_beats;
  logic [DATASIZE-1:0] r_mdata;
  logic                r_mvalid;
  logic                r_mlast;
  logic                r_busy;

  logic [PW-1:0]       w_wbin;
  logic [PW-1:0]       w_level;
  logic [PW-1:0]       w_rbin_nxt;
  logic [PW-1:0]       w_rgray_nxt;
  logic                w_full;
  logic                w_short;
  logic                w_start;
  logic                w_rd;
  logic                w_tmo;

  // Gray-to-binary of the synchronized write pointer
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i < PW; i++) begin
      w_wbin[i] = ^(rq2_wptr >> i);
    end
  end

  assign w_level     = w_wbin - r_rbin;
  assign w_full      = (w_level >= BL);
  assign w_short     = (flush || w_tmo) && (w_level != '0);
  assign w_start     = w_full || w_short;
  assign w_rd        = (r_state == S_BURST)
                    && (!r_mvalid || m.m_ready)
                    && (r_beats < r_blen);
  assign w_rbin_nxt  = r_rbin + {{(PW-1){1'b0}}, w_rd};
  assign w_rgray_nxt = (w_rbin_nxt >> 1) ^ w_rbin_nxt;

`ifdef RFIFO_DRAIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;

  assign w_tmo = (r_tcnt == TW'(TIMEOUT_CYCLES));

  // Age a short idle backlog; clears on empty or burst start
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_tcnt <= '0;
    end else if (r_state != S_IDLE || w_level == '0 || w_start) begin
      r_tcnt <= '0;
    end else if (w_level < BL && !w_tmo) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Read pointer, its Gray image and the registered empty flag
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin   <= '0;
      r_rptr   <= '0;
      r_rempty <= 1'b1;
    end else begin
      r_rbin   <= w_rbin_nxt;
      r_rptr   <= w_rgray_nxt;
      r_rempty <= (w_rgray_nxt == rq2_wptr);
    end
  end

  // Burst scheduler with registered stream outputs
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state  <= S_IDLE;
      r_blen   <= '0;
      r_beats  <= '0;
      r_mdata  <= '0;
      r_mvalid <= 1'b0;
      r_mlast  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_BURST;
            r_busy  <= 1'b1;
            r_blen  <= w_full ? BL : w_level;
            r_beats <= '0;
          end
        end
        S_BURST: begin
          if (w_rd) begin
            r_mdata  <= rdata;
            r_mvalid <= 1'b1;
            r_mlast  <= (r_beats + 1'b1 == r_blen);
            r_beats  <= r_beats + 1'b1;
            if (r_beats + 1'b1 == r_blen) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (m.m_ready) begin
            r_mvalid <= 1'b0;
            r_mlast  <= 1'b0;
            if (w_start) begin
              r_state <= S_BURST;
              r_blen  <= w_full ? BL : w_level;
              r_beats <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign raddr     = r_rbin[ADDRSIZE-1:0];
  assign rptr      = r_rptr;
  assign rempty    = r_rempty;
  assign busy      = r_busy;
  assign m.m_data  = r_mdata;
  assign m.m_valid = r_mvalid;
  assign m.m_last  = r_mlast;

endmodule

// File: tb/tb_rfifo_burst_drain_ctrl.sv
// Bench for rfifo_burst_drain_ctrl: FIFO memory, word/burst queue model.
// Honours RFIFO_DRAIN_TIMEOUT_EN for the timeout scenario.
module tb_rfifo_burst_drain_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   wptr;
  logic [DW-1:0] rdata;
  logic          flush;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic          busy;
  logic [DW-1:0] mem [16];

  always #5 clk = ~clk;

  rfifo_burst_drain_ctrl_if #(.DATASIZE(DW)) u_if();

  rfifo_burst_drain_ctrl #(
    .ADDRSIZE(AW),
    .DATASIZE(DW),
    .BURST_LEN(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .rclk(clk),
    .rrst_n(rst_n),
    .rq2_wptr(wptr),
    .rdata(rdata),
    .flush(flush),
    .raddr(raddr),
    .rptr(rptr),
    .rempty(rempty),
    .busy(busy),
    .m(u_if)
  );

  assign rdata = mem[raddr];

  int          checks = 0;
  int          errors = 0;
  int unsigned wr_cnt = 0;
  int unsigned acc_cnt = 0;
  logic [DW-1:0] exp_q[$];
  int          blen_q[$];
  int          beat = 0;
  int          rdy_mode = 0;
  int          ph = 0;
  int          lat;
  int          cnt;
  logic          pv_stall = 1'b0;
  logic [DW-1:0] pv_data;
  logic          pv_last;
  logic [DW-1:0] mon_d;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW:0] gray(input int unsigned b);
    logic [AW:0] t;
    t = b[AW:0];
    return t ^ (t >> 1);
  endfunction

  task automatic push(input logic [DW-1:0] d);
    mem[wr_cnt[AW-1:0]] = d;
    wr_cnt++;
    exp_q.push_back(d);
    wptr = gray(wr_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < 500), 1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic measure_lat(input int lim);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!u_if.m_valid && lat < lim);
  endtask

  // Consumer ready pattern
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: u_if.m_ready = (ph % 4 == 0) || (ph % 4 == 3);
      2: u_if.m_ready = 1'($urandom_range(0, 1));
      default: u_if.m_ready = 1'b1;
    endcase
    ph++;
  end

  // Stream monitor against the word and burst-length queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv_stall) begin
        chk("hold_valid", 32'(u_if.m_valid), 1);
        chk("hold_data", 32'(u_if.m_data), 32'(pv_data));
        chk("hold_last", 32'(u_if.m_last), 32'(pv_last));
      end
      if (u_if.m_valid && u_if.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(u_if.m_valid), 0);
        end else begin
          mon_d = exp_q.pop_front();
          chk("data", 32'(u_if.m_data), 32'(mon_d));
          acc_cnt++;
          beat++;
          if (blen_q.size() == 0) begin
            chk("unplanned_beat", 32'(u_if.m_valid), 0);
          end else begin
            chk("last", 32'(u_if.m_last), 32'(beat == blen_q[0]));
            if (beat == blen_q[0]) begin
              void'(blen_q.pop_front());
              beat = 0;
            end
          end
        end
      end
      pv_stall = u_if.m_valid && !u_if.m_ready;
      pv_data  = u_if.m_data;
      pv_last  = u_if.m_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int k;
    int groups;
    int guard;
    wptr = '0;
    flush = 1'b0;
    u_if.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    repeat (3) tick();
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_valid", 32'(u_if.m_valid), 0);
    chk("rst_last", 32'(u_if.m_last), 0);
    chk("rst_rptr", 32'(rptr), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (u_if.m_valid || busy || !rempty || raddr != 0) cnt++;
    end
    chk("idle50", cnt, 0);

    // single full burst with latency
    blen_q.push_back(4);
    for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
    measure_lat(20);
    chk("lat_full", lat, 2);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", 32'(u_if.m_valid), 1);
      tick();
    end
    wait_idle();
    chk("t2_rptr", 32'(rptr), 32'(gray(4)));
    chk("t2_rempty", 32'(rempty), 1);

    // short backlog waits for flush
    for (int i = 0; i < 3; i++) push(8'(8'hB0 + i));
    repeat (10) tick();
    chk("short_hold", exp_q.size(), 3);
    chk("short_busy", 32'(busy), 0);
    chk("short_rempty", 32'(rempty), 0);
    blen_q.push_back(3);
    pulse_flush();
    wait_idle();

    // stalled consumer, two bursts
    rdy_mode = 1;
    blen_q.push_back(4);
    blen_q.push_back(4);
    for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
    wait_idle();

    // randomized groups of four
    rdy_mode = 2;
    groups = 0;
    guard = 0;
    while (groups < 10 && guard < 2000) begin
      repeat ($urandom_range(0, 6)) tick();
      if (wr_cnt - acc_cnt <= 12) begin
        for (int i = 0; i < 4; i++) push(8'($urandom));
        blen_q.push_back(4);
        groups++;
      end
      tick();
      guard++;
    end
    wait_idle();
    rdy_mode = 0;

    // position read pointer at binary 30, then wrap
    k = int'((32 + 30 - (wr_cnt % 32)) % 32);
    while (k >= 4) begin
      for (int i = 0; i < 4; i++) push(8'($urandom));
      blen_q.push_back(4);
      wait_idle();
      k -= 4;
    end
    if (k > 0) begin
      for (int i = 0; i < k; i++) push(8'($urandom));
      blen_q.push_back(k);
      pulse_flush();
      wait_idle();
    end
    chk("wrap_raddr0", 32'(raddr), 14);
    blen_q.push_back(4);
    for (int i = 0; i < 4; i++) push(8'(8'hD0 + i));
    wait_idle();
    chk("wrap_raddr", 32'(raddr), 2);
    chk("wrap_rptr", 32'(rptr), 32'(gray(34)));
    chk("wrap_rempty", 32'(rempty), 1);

    // short backlog with no flush
    push(8'hE0);
    push(8'hE1);
`ifdef RFIFO_DRAIN_TIMEOUT_EN
    blen_q.push_back(2);
    measure_lat(40);
    chk("tmo_lat", lat, 18);
    wait_idle();
`else
    repeat (40) tick();
    chk("no_tmo", exp_q.size(), 2);
    chk("no_tmo_busy", 32'(busy), 0);
    blen_q.push_back(2);
    pulse_flush();
    wait_idle();
`endif

    chk("end_words", exp_q.size(), 0);
    chk("end_bursts", blen_q.size(), 0);
    chk("end_rempty", 32'(rempty), 1);
    chk("end_rptr", 32'(rptr), 32'(gray(wr_cnt)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
